// File: rtl/demux_drive_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_drive_seq_pkg
// Description : Shared definitions for the 1x8 demux drive sequencer:
//               sequencer state encoding, channel count and the upper
//               bound on the per-channel hold time.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_drive_seq_pkg;

    localparam int NCH      = 8;
    localparam int HOLD_MAX = 15;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        WAIT  = 3'd2,
        DRIVE = 3'd3,
        FIN   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/demux1x8.sv
`default_nettype none
// ============================================================================
// Module      : demux1x8
// Description : Plain 1-to-8 demultiplexer placed downstream of the
//               sequencer. Channel n = 4*s0 + 2*s1 + s2; unselected
//               outputs are 0.
// Ports       : i_d            data in
//               i_s0,i_s1,i_s2 selects (s0 is the MSB)
//               o_i0..o_i7     demux outputs
// Revision    : 1.0 - initial release
// ============================================================================
module demux1x8 (
    input  logic i_d,
    input  logic i_s0,
    input  logic i_s1,
    input  logic i_s2,
    output logic o_i0,
    output logic o_i1,
    output logic o_i2,
    output logic o_i3,
    output logic o_i4,
    output logic o_i5,
    output logic o_i6,
    output logic o_i7
);

    logic [2:0] w_sel;

    assign w_sel = {i_s0, i_s1, i_s2};

    assign o_i0 = i_d & (w_sel == 3'd0);
    assign o_i1 = i_d & (w_sel == 3'd1);
    assign o_i2 = i_d & (w_sel == 3'd2);
    assign o_i3 = i_d & (w_sel == 3'd3);
    assign o_i4 = i_d & (w_sel == 3'd4);
    assign o_i5 = i_d & (w_sel == 3'd5);
    assign o_i6 = i_d & (w_sel == 3'd6);
    assign o_i7 = i_d & (w_sel == 3'd7);

endmodule
`default_nettype wire

// File: rtl/demux_drive_seq_prio_find.sv
`default_nettype none
// ============================================================================
// Module      : demux_prio_find
// Description : Combinational finder returning the lowest set mask bit whose
//               index is at or above a start pointer.
// Ports       : i_mask  [NCH-1:0] channel enable mask
//               i_ptr   [3:0]     first index eligible (8 = nothing eligible)
//               o_idx   [2:0]     index of lowest eligible set bit
//               o_found           1 when such a bit exists
// Revision    : 1.0 - initial release
// ============================================================================
module demux_prio_find
    import demux_drive_seq_pkg::*;
(
    input  logic [NCH-1:0] i_mask,
    input  logic [3:0]     i_ptr,
    output logic [2:0]     o_idx,
    output logic           o_found
);

    // Scanning from the top down lets the last hit (the lowest index) win.
    always_comb begin
        o_idx   = 3'd0;
        o_found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (i_mask[i] && (4'(i) >= i_ptr)) begin
                o_idx   = 3'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/demux_drive_seq.sv
`default_nettype none
// ============================================================================
// Module      : demux_drive_seq
// Description : Sweeps the enabled channels of a 1x8 demux in ascending
//               order. For each enabled channel it waits for one upstream
//               data beat, then holds that bit on d for HOLD cycles. Selects
//               only move while d=0, so a wrong output never sees a glitch.
// Parameters  : HOLD      cycles d is held per channel, legal 1..HOLD_MAX
// Ports       : clk, rst_n   clock, asynchronous active-low reset
//               i_start      one-cycle sweep request (IDLE only)
//               i_abort      synchronous sweep cancel
//               i_ch_mask    channel enables, captured on accepted start
//               i_in_valid   upstream beat valid
//               i_in_data    upstream beat data bit
//               o_in_ready   beat accepted when valid & ready
//               o_d          registered demux data
//               o_s0..o_s2   registered demux selects
//               o_busy       high outside IDLE
//               o_done       one-cycle pulse on normal completion
//               o_cur_ch     {s0,s1,s2}
// Revision    : 1.0 - initial release
// ============================================================================
module demux_drive_seq
    import demux_drive_seq_pkg::*;
#(
    parameter int HOLD = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_start,
    input  logic           i_abort,
    input  logic [NCH-1:0] i_ch_mask,
    input  logic           i_in_valid,
    input  logic           i_in_data,
    output logic           o_in_ready,
    output logic           o_d,
    output logic           o_s0,
    output logic           o_s1,
    output logic           o_s2,
    output logic           o_busy,
    output logic           o_done,
    output logic [2:0]     o_cur_ch
);

    localparam logic [3:0] c_hold_load = 4'(HOLD - 1);

    state_t         r_state;
    logic [NCH-1:0] r_mask_q;
    logic [3:0]     r_ptr;       // 8 marks end of sweep; never wraps
    logic [3:0]     r_hold_cnt;
    logic [2:0]     r_sel;
    logic           r_d;
    logic           r_in_ready;
    logic           r_busy;
    logic           r_done;

    logic [2:0]     w_idx;
    logic           w_found;

    demux_prio_find u_prio_find (
        .i_mask  (r_mask_q),
        .i_ptr   (r_ptr),
        .o_idx   (w_idx),
        .o_found (w_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_mask_q   <= '0;
            r_ptr      <= 4'd0;
            r_hold_cnt <= 4'd0;
            r_sel      <= 3'd0;
            r_d        <= 1'b0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            // done is a pulse: only the transition into FIN raises it.
            r_done <= 1'b0;
            if (i_abort && (r_state != IDLE)) begin
                r_state    <= IDLE;
                r_d        <= 1'b0;
                r_in_ready <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (i_start && !i_abort) begin
                            r_mask_q <= i_ch_mask;
                            r_ptr    <= 4'd0;
                            r_busy   <= 1'b1;
                            r_state  <= SCAN;
                        end
                    end
                    SCAN: begin
                        if (w_found) begin
                            // d is already 0 here, so moving selects is safe.
                            r_sel      <= w_idx;
                            r_d        <= 1'b0;
                            r_in_ready <= 1'b1;
                            r_state    <= WAIT;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= FIN;
                        end
                    end
                    WAIT: begin
                        if (i_in_valid) begin
                            r_d        <= i_in_data;
                            r_in_ready <= 1'b0;
                            r_hold_cnt <= c_hold_load;
                            r_state    <= DRIVE;
                        end
                    end
                    DRIVE: begin
                        if (r_hold_cnt == 4'd0) begin
                            // Guard cycle: d returns to 0 before any select move.
                            r_d   <= 1'b0;
                            r_ptr <= {1'b0, r_sel} + 4'd1;
                            if (r_sel == 3'd7) begin
                                r_done  <= 1'b1;
                                r_state <= FIN;
                            end else begin
                                r_state <= SCAN;
                            end
                        end else begin
                            r_hold_cnt <= r_hold_cnt - 4'd1;
                        end
                    end
                    FIN: begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                    default: begin
                        r_d        <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= IDLE;
                    end
                endcase
            end
        end
    end

    assign o_in_ready = r_in_ready;
    assign o_d        = r_d;
    assign o_s0       = r_sel[2];
    assign o_s1       = r_sel[1];
    assign o_s2       = r_sel[0];
    assign o_cur_ch   = r_sel;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule
`default_nettype wire

// File: doc/demux_drive_seq.md
DEMUX_DRIVE_SEQ -- requirements
Module: demux_drive_seq

Interface
REQ-001 The block SHALL have parameter HOLD, default 2, meaning the number of cycles `d` is held high or low on one channel; legal range is 1..15.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle request to begin one sweep; sampled only in IDLE.
REQ-005 abort  input  1  synchronous sweep cancel.
REQ-006 ch_mask  input  8  channel enables; bit n enables demux output in; captured on accepted start.
REQ-007 in_valid  input  1  upstream data beat valid.
REQ-008 in_data  input  1  upstream data bit.
REQ-009 in_ready  output  1  the block accepts a beat when in_valid and in_ready are both 1 in the same cycle.
REQ-010 d  output  1  registered data to the 1x8 demux.
REQ-011 s0, s1, s2  output  1 each  registered selects; channel n = 4*s0 + 2*s1 + s2.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse at normal sweep completion.
REQ-014 cur_ch  output  3  channel currently selected; equals {s0,s1,s2}.

Function
REQ-015 The FSM SHALL have states IDLE, SCAN, WAIT, DRIVE and FIN.
REQ-016 IDLE: when start=1, latch ch_mask into mask_q, set ptr=0, and go to SCAN.
REQ-017 SCAN (one cycle): find the lowest n >= ptr with mask_q[n]=1; if one exists, load selects with n, hold d=0, and go to WAIT; otherwise go to FIN.
REQ-018 WAIT: in_ready=1 and d=0; on a beat, register in_data, go to DRIVE, and drop in_ready the next cycle.
REQ-019 DRIVE: d SHALL equal the captured bit for exactly HOLD cycles, with selects stable.
REQ-020 On leaving DRIVE, d SHALL return to 0 in the following cycle, and ptr=n+1.
REQ-021 After DRIVE: if n=7, go to FIN; else go to SCAN.
REQ-022 Select lines SHALL change only in cycles where d=0, giving a guard cycle between channels with no glitch onto a wrong output.
REQ-023 FIN: done=1 for one cycle, then go to IDLE; selects keep the last value.
REQ-024 start with ch_mask=0 SHALL go IDLE->SCAN->FIN: done pulses and d never asserts.
REQ-025 start while busy SHALL be ignored, and ch_mask changes during a sweep SHALL have no effect.
REQ-026 abort=1 in any non-IDLE state SHALL force d=0 and in_ready=0 the next cycle, go to IDLE, and suppress done.
REQ-027 abort in IDLE is a no-op.
REQ-028 abort together with start in IDLE: abort wins and no sweep starts.
REQ-029 in_valid outside WAIT SHALL be ignored, with in_ready=0.
REQ-030 ptr is 4 bits so that ptr=8 means sweep end with no wrap.
REQ-031 The hold counter is 4 bits and counts HOLD-1 down to 0.

Reset
REQ-032 When rst_n=0, the block SHALL go immediately (asynchronously) to IDLE with d=0, s0=s1=s2=0, cur_ch=0, in_ready=0, busy=0, done=0, mask_q=0, ptr=0, hold counter=0.
REQ-033 Reset asserted mid-DRIVE SHALL drop d to 0 without waiting for a clock edge.
REQ-034 The first start after reset release SHALL be honoured on the first clock edge where rst_n=1.

Structure
REQ-035 The shared package SHALL hold the state enum (IDLE, SCAN, WAIT, DRIVE, FIN), constant NCH=8, and constant HOLD_MAX=15.
REQ-036 One sub-module SHALL be used: demux_prio_find, a combinational lowest-set-bit-at-or-above-ptr finder taking 8-bit mask and 4-bit ptr and giving 3-bit index plus found flag.
REQ-037 All outputs SHALL be driven directly from flops.
REQ-038 The verification bench SHALL instantiate demux1x8 downstream and check its i0..i7.

Verification
REQ-039 ch_mask=8'hFF, HOLD=2, in_data 1,0,1,1,0,0,1,0 always valid -> i0..i7 each pulse per data bit for 2 cycles in order 0..7, guard cycle between channels, done after ch7, 8 beats accepted.
REQ-040 ch_mask=8'b1000_0101, in_data=1 -> only i0, i2, i7 pulse, in that order, and exactly 3 beats are accepted.
REQ-041 ch_mask=0, start -> done 2 cycles after start, d stays 0, no beat accepted.
REQ-042 ch_mask=8'hFF, in_valid held 0 for 10 cycles in WAIT on ch0 -> d=0, selects=0, busy=1 throughout; then one beat leads to DRIVE.
REQ-043 abort during ch3 DRIVE -> d=0 the next cycle, IDLE, no done; a new start with ch_mask=8'h01 then drives only i0.
REQ-044 rst_n low mid-DRIVE on ch5 -> d and selects become 0 asynchronously; start after release sweeps from ch0.
